// File: rtl/fir_filter_prog.sv
// rtl/fir_filter_prog.sv - programmable FIR with runtime coefficient writes, 3-stage pipeline,
// rounding right-shift and output saturation.
module fir_filter_prog #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   x_in,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       out_valid,
  output logic signed [OUT_W-1:0]    y_out,
  output logic                       sat_flag
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  // One spare bit keeps the rounding add from wrapping; RW also covers OUT_W for the limits.
  localparam int RW     = ((ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W) + 1;

  localparam logic signed [RW-1:0] RND  =
    (SHIFT > 0) ? (RW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [DATA_W-1:0] tap  [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PROD_W-1:0] prod [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [RW-1:0]     rnd;
  logic signed [RW-1:0]     r;
  logic                     v0, v1, v2;

  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum = sum + ACC_W'(prod[i]);
    end
    rnd = RW'(acc) + RND;
    r   = rnd >>> SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        tap[i]  <= '0;
        coef[i] <= '0;
        prod[i] <= '0;
      end
      acc       <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      y_out     <= '0;
      sat_flag  <= 1'b0;
    end else begin
      v0 <= in_valid;
      if (in_valid) begin
        tap[0] <= x_in;
        for (int i = 1; i < TAPS; i++) begin
          tap[i] <= tap[i-1];
        end
      end
      // Addresses with no matching tap fall through every compare and are dropped.
      for (int i = 0; i < TAPS; i++) begin
        if (coef_we && coef_addr == ADDR_W'(i)) begin
          coef[i] <= coef_data;
        end
      end
      for (int i = 0; i < TAPS; i++) begin
        prod[i] <= PROD_W'(tap[i]) * PROD_W'(coef[i]);
      end
      v1        <= v0;
      acc       <= sum;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        if (r > MAXV) begin
          y_out    <= {1'b0, {(OUT_W-1){1'b1}}};
          sat_flag <= 1'b1;
        end else if (r < MINV) begin
          y_out    <= {1'b1, {(OUT_W-1){1'b0}}};
          sat_flag <= 1'b1;
        end else begin
          y_out    <= r[OUT_W-1:0];
          sat_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/fir_filter_prog.md
# fir_filter_prog

Programmable, pipelined, parametrised FIR filter: the next-generation FIR block for the datapath. It replaces fixed built-in coefficients with a runtime coefficient write port. It accepts samples only on a valid strobe, so the delay line holds across gaps. Output uses a fixed 3-stage pipeline with valid tracking, configurable right-shift with rounding, and saturation to the output width. It sits between the sample source and downstream DSP/output logic, one sample per clock at most.

## Interface

- DATA_W, 8, signed input sample width
- COEF_W, 8, signed coefficient width
- TAPS, 4, number of taps (≥2)
- OUT_W, 16, signed output width
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation (0 ≤ SHIFT < ACC_W)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  x_in is accepted on this edge when high
- x_in  in  DATA_W  signed input sample
- coef_we  in  1  coefficient write enable
- coef_addr  in  $clog2(TAPS)  tap index to write
- coef_data  in  COEF_W  signed coefficient value
- out_valid  out  1  y_out carries a new result this cycle (one-cycle pulse per accepted sample)
- y_out  out  OUT_W  signed filtered output, holds last value between results
- sat_flag  out  1  high with out_valid when the result was clipped

## Operation

- Derived widths: PROD_W = DATA_W+COEF_W; ACC_W = PROD_W+$clog2(TAPS). All arithmetic signed; no intermediate overflow is possible.
- Delay line tap[0..TAPS-1]: on an edge with in_valid=1, tap[i] <= tap[i-1] and tap[0] <= x_in. With in_valid=0 it holds.
- Coefficient RAM coef[0..TAPS-1]: on an edge with coef_we=1, coef[coef_addr] <= coef_data. If coef_addr ≥ TAPS the write is ignored. Writes never stall or disturb the sample flow.
- Stage 1 (product): p[i] <= tap[i]*coef[i], registered every cycle; v1 <= accepted-last-edge flag.
- Stage 2 (sum): acc <= Σ p[i]; v2 <= v1.
- Stage 3 (output): r = (SHIFT>0) ? (acc + 2^(SHIFT-1)) >>> SHIFT : acc, i.e. round half toward +∞.
  - If r > 2^(OUT_W-1)-1, y_out = max and sat_flag = 1.
  - If r < -2^(OUT_W-1), y_out = min and sat_flag = 1.
  - Otherwise y_out = r[OUT_W-1:0] and sat_flag = 0.
  - y_out and sat_flag update only when v2=1. out_valid <= v2.
- Reset (any cycle, including mid-stream) clears all taps, coefs, pipeline registers, valid flags, y_out, out_valid and sat_flag to 0. In-flight samples are discarded and produce no out_valid.

## Timing

- Sample accepted at edge k → out_valid=1 and y_out valid after edge k+3. Fixed latency 3, throughput 1 sample per cycle.
- Back-to-back in_valid gives back-to-back out_valid. Gaps in in_valid reproduce the same gaps 3 cycles later.
- Coefficient visibility: a sample accepted at edge k uses coef values present after edge k.
  - A write on the same edge as an accept applies to that sample.
  - Writes at edge k+1 or later do not affect it.
- Coef write and reset on the same edge: reset wins.
- in_valid during reset is ignored.
- First accept is allowed on the edge after reset deasserts. Its out_valid follows 3 edges later.
- sat_flag is meaningful only when out_valid=1 and holds with y_out otherwise.

## Test plan

- Impulse (defaults): write coefs 2,4,4,2 to addr 0..3, then x_in = 1,0,0,0 with in_valid continuous → out_valid on 4 consecutive cycles with y_out = 2,4,4,2, starting 3 edges after the first accept, sat_flag = 0.
- Gapped step: coefs 2,4,4,2, x_in = 10 with in_valid high every other cycle for 5 samples → y_out = 20,60,100,120,120 with out_valid pattern matching the input gaps delayed by 3.
- Saturation: all coefs −128, four samples of −128 → 4th y_out = 32767 with sat_flag = 1. All coefs −128, four samples of 127 → 4th y_out = −32768 with sat_flag = 1. Earlier outputs (16384, 32768→32767 clipped) are checked individually.
- Rounding (SHIFT=2 instance): coefs 1,0,0,0, x = 6 → y_out = 2; x = −6 → y_out = −1; x = 5 → y_out = 1.
- Coef write coincident with accept: coef[0] = 1, then on the same edge write coef[0] = 3 and accept x = 7 → y_out = 21. Writing coef[0] = 5 one edge after an accept of x = 7 → that result is 21, not 35. A write to addr ≥ TAPS (TAPS=3 instance) changes nothing.
- Reset mid-stream: accept 3 samples, assert reset for 1 cycle while 2 samples are in flight → no out_valid for the discarded samples. y_out = 0, all coefs = 0 after reset, so a fresh impulse yields all-zero outputs until coefs are rewritten.
